fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch unit for the RV32I pipeline. It owns the program counter and issues sequential word fetches to instruction memory over a valid/ready request channel. In-order responses are buffered in a DEPTH-entry queue that feeds decode over a valid/ready channel. A redirect from execute reloads the PC, flushes the queue and discards every response still in flight.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch unit bundle: redirect input, instruction-memory request/response
// channels and the decode-side output channel.
interface fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: owns the PC, issues credit-limited sequential fetches
// and buffers in-order responses in a DEPTH-entry queue feeding decode.
module fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          rsp_valid,
  input logic [CW-1:0] out_cnt,
  input logic [CW-1:0] q_cnt
);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  // A response with nothing outstanding would underflow the in-flight count.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (out_cnt != {CW{1'b0}}));

  // Credit accounting keeps in-flight plus buffered within the queue size.
  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, out_cnt} + {1'b0, q_cnt}) <= DEPTH_W);
endmodule

module fetch_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
  localparam logic [AW-1:0]   PTR_ONE    = AW'(1'b1);
  localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [CW-1:0]   out_cnt_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   q_cnt_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [XLEN-1:0] mem_pc_r    [DEPTH];
  logic [ILEN-1:0] mem_instr_r [DEPTH];

  logic            credit_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            enq_s;
  logic            pop_s;
  logic [XLEN-1:0] redirect_tgt_s;
  logic [CW-1:0]   rsp_dec_s;
  logic [CW-1:0]   out_cnt_nxt_s;
  logic [CW-1:0]   q_cnt_nxt_s;

  // Credit is purely registered, so only redirect/reset gate the request combinationally.
  assign credit_s       = ({1'b0, out_cnt_r} + {1'b0, q_cnt_r}) < DEPTH_W;
  assign req_valid_s    = credit_s && !bus.redirect_valid && !reset;
  assign req_fire_s     = req_valid_s && bus.imem_req_ready;
  assign enq_s          = bus.imem_rsp_valid && (drop_cnt_r == CNT_ZERO);
  assign pop_s          = (q_cnt_r != CNT_ZERO) && bus.out_ready;
  assign redirect_tgt_s = bus.redirect_pc & ALIGN_MASK;
  assign rsp_dec_s      = bus.imem_rsp_valid ? (out_cnt_r - CNT_ONE) : out_cnt_r;

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_r;
  assign bus.out_valid      = (q_cnt_r != CNT_ZERO);
  assign bus.out_pc         = mem_pc_r[rd_ptr_r];
  assign bus.out_instr      = mem_instr_r[rd_ptr_r];

  // Next in-flight and queue occupancy counts for the non-redirect case.
  always_comb begin
    out_cnt_nxt_s = out_cnt_r;
    q_cnt_nxt_s   = q_cnt_r;
    if (req_fire_s && !bus.imem_rsp_valid) begin
      out_cnt_nxt_s = out_cnt_r + CNT_ONE;
    end else if (!req_fire_s && bus.imem_rsp_valid) begin
      out_cnt_nxt_s = out_cnt_r - CNT_ONE;
    end else begin
      out_cnt_nxt_s = out_cnt_r;
    end
    if (enq_s && !pop_s) begin
      q_cnt_nxt_s = q_cnt_r + CNT_ONE;
    end else if (!enq_s && pop_s) begin
      q_cnt_nxt_s = q_cnt_r - CNT_ONE;
    end else begin
      q_cnt_nxt_s = q_cnt_r;
    end
  end

  // PC, response tracking and queue state; redirect overrides everything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      out_cnt_r  <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
      q_cnt_r    <= CNT_ZERO;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]    <= {XLEN{1'b0}};
        mem_instr_r[i] <= {ILEN{1'b0}};
      end
    end else if (bus.redirect_valid) begin
      pc_r       <= redirect_tgt_s;
      rsp_pc_r   <= redirect_tgt_s;
      q_cnt_r    <= CNT_ZERO;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      // Everything still outstanding belongs to the old path, including a
      // response landing this very cycle.
      out_cnt_r  <= rsp_dec_s;
      drop_cnt_r <= rsp_dec_s;
    end else begin
      if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end
      out_cnt_r <= out_cnt_nxt_s;
      if (bus.imem_rsp_valid) begin
        if (drop_cnt_r != CNT_ZERO) begin
          drop_cnt_r <= drop_cnt_r - CNT_ONE;
        end else begin
          mem_pc_r[wr_ptr_r]    <= rsp_pc_r;
          mem_instr_r[wr_ptr_r] <= bus.imem_rsp_data;
          wr_ptr_r              <= wr_ptr_r + PTR_ONE;
          rsp_pc_r              <= rsp_pc_r + PC_STEP;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      q_cnt_r <= q_cnt_nxt_s;
    end
  end

  fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .rsp_valid (bus.imem_rsp_valid),
    .out_cnt   (out_cnt_r),
    .q_cnt     (q_cnt_r)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with programmable
// latency, request/pop order tracking and hand-computed scenario checks.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

  fetch_queue #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_fire = 0;
  logic [31:0] exp_req;
  logic [31:0] exp_pc;
  logic        s_req_valid;
  logic        s_out_valid;
  logic [31:0] s_req_addr;
  logic [31:0] s_out_pc;
  logic        fire_d;
  logic [31:0] fire_addr;
  logic        seen;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One clock: sample at negedge, track fires/pops, then advance the memory model.
  task automatic cycle();
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_out_valid = bus.out_valid;
    s_out_pc    = bus.out_pc;
    fire_d      = bus.imem_req_valid && bus.imem_req_ready;
    fire_addr   = bus.imem_req_addr;
    if (fire_d) begin
      chk("req_addr", {32'h0, fire_addr}, {32'h0, exp_req});
      exp_req = exp_req + 32'd4;
      n_fire++;
    end
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      chk("pop_pc", {32'h0, bus.out_pc}, {32'h0, exp_pc});
      chk("pop_instr", {32'h0, bus.out_instr}, {32'h0, instr_of(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fire_d) mq.push_back('{fire_addr, cyc + lat - 1});
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    exp_req = tgt & 32'hFFFF_FFFC;
    exp_pc  = tgt & 32'hFFFF_FFFC;
    cycle();
    chk("redir_req_gated", {63'h0, s_req_valid}, 64'h0);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] first_pc);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      seen = s_out_valid;
    end
    chk({tag, "_seen"}, {63'h0, seen}, 64'h1);
    chk({tag, "_first_pc"}, {32'h0, s_out_pc}, {32'h0, first_pc});
  endtask

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.out_ready      = 1'b1;
    exp_req            = 32'h100;
    exp_pc             = 32'h100;

    // Reset state.
    repeat (3) cycle();
    chk("rst_req_valid", {63'h0, s_req_valid}, 64'h0);
    chk("rst_out_valid", {63'h0, s_out_valid}, 64'h0);
    chk("rst_req_addr", {32'h0, s_req_addr}, 64'h100);
    chk("rst_out_pc", {32'h0, bus.out_pc}, 64'h0);
    chk("rst_out_instr", {32'h0, bus.out_instr}, 64'h0);

    // Streaming from RESET_PC with a one-cycle memory.
    reset = 1'b0;
    cycle();
    chk("first_req_valid", {63'h0, s_req_valid}, 64'h1);
    chk("first_req_addr", {32'h0, s_req_addr}, 64'h100);
    chk("c0_out_valid", {63'h0, s_out_valid}, 64'h0);
    cycle();
    chk("c1_out_valid", {63'h0, s_out_valid}, 64'h0);
    cycle();
    chk("c2_out_valid", {63'h0, s_out_valid}, 64'h1);
    chk("c2_out_pc", {32'h0, s_out_pc}, 64'h100);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("stream_valid", {63'h0, s_out_valid}, 64'h1);
    end

    // Decode stalled: exactly DEPTH requests, then credit release on pop.
    bus.out_ready = 1'b0;
    n_fire = 0;
    do_redirect(32'h0);
    repeat (8) cycle();
    chk("stall_fires", 64'(n_fire), 64'd4);
    chk("stall_req_valid", {63'h0, s_req_valid}, 64'h0);
    chk("stall_head_pc", {32'h0, s_out_pc}, 64'h0);
    bus.out_ready = 1'b1;
    cycle();
    chk("pop_cycle_req_valid", {63'h0, s_req_valid}, 64'h0);
    cycle();
    chk("credit_req_valid", {63'h0, s_req_valid}, 64'h1);
    chk("credit_req_addr", {32'h0, s_req_addr}, 64'h10);

    // Drain, then redirect with three requests in flight.
    bus.imem_req_ready = 1'b0;
    repeat (8) cycle();
    lat = 4;
    bus.imem_req_ready = 1'b1;
    repeat (3) cycle();
    do_redirect(32'h2003);
    cycle();
    chk("redir_next_valid", {63'h0, s_req_valid}, 64'h1);
    chk("redir_next_addr", {32'h0, s_req_addr}, 64'h2000);
    chk("redir_next_out_valid", {63'h0, s_out_valid}, 64'h0);
    wait_valid("redir2000", 32'h2000);

    // Redirect colliding with an old response and a decode pop.
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.out_valid && bus.imem_rsp_valid) seen = 1'b1;
      else cycle();
    end
    chk("collide_found", {63'h0, seen}, 64'h1);
    do_redirect(32'h3000);
    cycle();
    chk("collide_q_empty", {63'h0, s_out_valid}, 64'h0);
    wait_valid("redir3000", 32'h3000);

    // Toggling request ready with a three-cycle memory.
    lat = 3;
    for (int i = 0; i < 30; i++) begin
      bus.imem_req_ready = (i % 2 == 0);
      cycle();
    end
    bus.imem_req_ready = 1'b0;
    repeat (10) cycle();
    bus.out_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    n_fire = 0;
    repeat (8) cycle();
    chk("idle_credit_fires", 64'(n_fire), 64'd4);

    // Address wrap at the top of memory.
    lat = 1;
    bus.out_ready = 1'b1;
    do_redirect(32'hFFFF_FFF8);
    cycle();
    chk("wrap_addr0", {32'h0, s_req_addr}, 64'hFFFF_FFF8);
    cycle();
    chk("wrap_addr1", {32'h0, s_req_addr}, 64'hFFFF_FFFC);
    cycle();
    chk("wrap_addr2", {32'h0, s_req_addr}, 64'h0);
    repeat (4) cycle();

    // Reset asserted mid-stream, held past the memory latency.
    reset = 1'b1;
    #1;
    chk("mid_rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    chk("mid_rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("mid_rst_out_pc", {32'h0, bus.out_pc}, 64'h0);
    chk("mid_rst_out_instr", {32'h0, bus.out_instr}, 64'h0);
    exp_req = 32'h100;
    exp_pc  = 32'h100;
    repeat (5) cycle();
    reset = 1'b0;
    cycle();
    chk("post_rst_req_valid", {63'h0, s_req_valid}, 64'h1);
    chk("post_rst_req_addr", {32'h0, s_req_addr}, 64'h100);
    repeat (6) cycle();
    chk("post_rst_pops", {32'h0, exp_pc}, 64'h114);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
